// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//   In-order write-back queue in front of the register file's single write
//   port. ALU and load-unit results are enqueued (load first when both arrive
//   together) and drained one per cycle as we/rd/din. Pending entries can be
//   looked up by decode (rs1/rs2) for forwarding or stall decisions.
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   mem_valid/rd/data, ready  load-unit result handshake
//   alu_valid/rd/data, ready  ALU result handshake
//   wb_hold                   suppress draining this cycle
//   we, rd, din               register-file write port (driven from head)
//   rs1, rs2                  decode read addresses
//   rs1_hit/fwd, rs2_hit/fwd  pending-write lookup, youngest data wins
//   count                     occupied entries
module regfile_writeback_queue #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mem_valid,
    input  logic [AW-1:0]              mem_rd,
    input  logic [WIDTH-1:0]           mem_data,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [WIDTH-1:0]           alu_data,
    output logic                       alu_ready,
    input  logic                       wb_hold,
    output logic                       we,
    output logic [AW-1:0]              rd,
    output logic [WIDTH-1:0]           din,
    input  logic [AW-1:0]              rs1,
    input  logic [AW-1:0]              rs2,
    output logic                       rs1_hit,
    output logic                       rs2_hit,
    output logic [WIDTH-1:0]           rs1_fwd,
    output logic [WIDTH-1:0]           rs2_fwd,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C  = (PW+1)'(DEPTH);
    localparam logic [PW:0] DEPTH_M1 = (PW+1)'(DEPTH - 1);

    logic [PW-1:0]    head, tail, alu_idx;
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    ent_rd   [DEPTH];
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [PW-1:0]    age_idx  [DEPTH];

    logic mem_st, alu_st, pop;

    // Readies look only at the registered count; a drain in the same cycle
    // does not free a slot. The ALU needs two free slots when a load competes.
    assign mem_ready = (count < DEPTH_C);
    assign alu_ready = mem_valid ? (count < DEPTH_M1) : (count < DEPTH_C);

    // x0 results are handshaken but dropped.
    assign mem_st  = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_st  = alu_valid && alu_ready && (alu_rd != '0);
    assign alu_idx = tail + PW'(mem_st);

    assign we  = (count != '0) && !wb_hold;
    assign pop = we;
    assign rd  = we ? ent_rd[head]   : '0;
    assign din = we ? ent_data[head] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            // Push and pop never touch the same slot: empty forbids pop,
            // full forbids push.
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            if (mem_st) vld[tail]    <= 1'b1;
            if (alu_st) vld[alu_idx] <= 1'b1;
            tail  <= tail + PW'(mem_st) + PW'(alu_st);
            count <= count + (PW+1)'(mem_st) + (PW+1)'(alu_st) - (PW+1)'(pop);
        end
    end

    // Payload storage is not reset; vld qualifies every read.
    always_ff @(posedge clock) begin
        if (mem_st) begin
            ent_rd[tail]   <= mem_rd;
            ent_data[tail] <= mem_data;
        end
        if (alu_st) begin
            ent_rd[alu_idx]   <= alu_rd;
            ent_data[alu_idx] <= alu_data;
        end
    end

    // Slots listed oldest (head) to youngest.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign age_idx[g] = head + PW'(g);
    end

    // Walk oldest to youngest so the last match (youngest) sets the data.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rs1_fwd = '0;
        rs2_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[age_idx[i]] && (rs1 != '0) && (ent_rd[age_idx[i]] == rs1)) begin
                rs1_hit = 1'b1;
                rs1_fwd = ent_data[age_idx[i]];
            end
            if (vld[age_idx[i]] && (rs2 != '0) && (ent_rd[age_idx[i]] == rs2)) begin
                rs2_hit = 1'b1;
                rs2_fwd = ent_data[age_idx[i]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue (WIDTH=32, AW=5, DEPTH=4).
// Inputs change 1ns after a rising edge; outputs are checked before the next.
module tb_regfile_writeback_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0, alu_valid = 1'b0, wb_hold = 1'b0;
    logic [4:0]  mem_rd = '0, alu_rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic        mem_ready, alu_ready, we, rs1_hit, rs2_hit;
    logic [4:0]  rd;
    logic [31:0] din, rs1_fwd, rs2_fwd;
    logic [2:0]  count;

    int nvec = 0;
    int nmis = 0;

    regfile_writeback_queue #(.WIDTH(32), .AW(5), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_hold(wb_hold), .we(we), .rd(rd), .din(din),
        .rs1(rs1), .rs2(rs2), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ---- reset state
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_din", din, 0);
        chk("rst_mem_ready", 32'(mem_ready), 1);
        chk("rst_alu_ready", 32'(alu_ready), 1);
        chk("rst_hit", 32'(rs1_hit), 0);
        reset = 1'b0;
        tick();

        // ---- 1: single ALU write, one-cycle latency
        alu_valid = 1; alu_rd = 2; alu_data = 32'h1;
        tick();
        alu_valid = 0;
        chk("t1_count", 32'(count), 1);
        chk("t1_we", 32'(we), 1);
        chk("t1_rd", 32'(rd), 2);
        chk("t1_din", din, 32'h1);
        tick();
        chk("t1_count_after", 32'(count), 0);
        chk("t1_we_after", 32'(we), 0);

        // ---- 2: simultaneous mem+alu to same rd, youngest forwarded
        wb_hold = 1;
        mem_valid = 1; mem_rd = 3; mem_data = 32'h5;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h6;
        #1;
        chk("t2_alu_ready", 32'(alu_ready), 1);
        tick();
        mem_valid = 0; alu_valid = 0;
        rs1 = 3;
        #1;
        chk("t2_count", 32'(count), 2);
        chk("t2_we_held", 32'(we), 0);
        chk("t2_hit", 32'(rs1_hit), 1);
        chk("t2_fwd", rs1_fwd, 32'h6);
        wb_hold = 0;
        #1;
        chk("t2_rd0", 32'(rd), 3);
        chk("t2_din0", din, 32'h5);
        tick();
        chk("t2_rd1", 32'(rd), 3);
        chk("t2_din1", din, 32'h6);
        chk("t2_count1", 32'(count), 1);
        chk("t2_hit_head", 32'(rs1_hit), 1);
        chk("t2_fwd_head", rs1_fwd, 32'h6);
        tick();
        chk("t2_count_end", 32'(count), 0);
        chk("t2_hit_end", 32'(rs1_hit), 0);

        // ---- 3: fill under hold, ready boundaries, ordered drain
        wb_hold = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_valid = 1; mem_rd = 0;
                #1;
                chk("t3_alu_ready_c3_mv", 32'(alu_ready), 0);
                chk("t3_mem_ready_c3", 32'(mem_ready), 1);
                mem_valid = 0;
                #1;
                chk("t3_alu_ready_c3", 32'(alu_ready), 1);
            end
            alu_valid = 1; alu_rd = 5'(i + 1); alu_data = 32'(10 + i);
            tick();
        end
        alu_rd = 9; alu_data = 32'h99;   // must be refused at full
        #1;
        chk("t3_count_full", 32'(count), 4);
        chk("t3_alu_ready_full", 32'(alu_ready), 0);
        chk("t3_mem_ready_full", 32'(mem_ready), 0);
        rs1 = 5; rs2 = 4;
        #1;
        chk("t3_rs1_miss", 32'(rs1_hit), 0);
        chk("t3_rs2_hit", 32'(rs2_hit), 1);
        chk("t3_rs2_fwd", rs2_fwd, 32'd13);
        tick();
        alu_valid = 0;
        chk("t3_count_refused", 32'(count), 4);
        wb_hold = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_drain_we", 32'(we), 1);
            chk("t3_drain_rd", 32'(rd), 32'(i + 1));
            chk("t3_drain_din", din, 32'(10 + i));
            tick();
        end
        chk("t3_count_end", 32'(count), 0);
        rs1 = 0; rs2 = 0;

        // ---- 4: ten back-to-back writes, pointers wrap
        for (int i = 1; i <= 10; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'(100 + i);
            tick();
            chk("t4_we", 32'(we), 1);
            chk("t4_rd", 32'(rd), 32'(i));
            chk("t4_din", din, 32'(100 + i));
            chk("t4_count", 32'(count), 1);
        end
        alu_valid = 0;
        tick();
        chk("t4_count_end", 32'(count), 0);
        chk("t4_we_end", 32'(we), 0);

        // ---- 5: x0 write is accepted but dropped
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        #1;
        chk("t5_alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 0;
        chk("t5_count", 32'(count), 0);
        chk("t5_we", 32'(we), 0);
        rs1 = 0;
        #1;
        chk("t5_hit", 32'(rs1_hit), 0);
        tick();
        chk("t5_we_later", 32'(we), 0);

        // ---- 6: async reset mid-cycle with entries pending
        wb_hold = 1;
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'(20 + i);
            tick();
        end
        alu_valid = 0;
        rs1 = 2;
        #1;
        chk("t6_count_pre", 32'(count), 3);
        chk("t6_fwd_pre", rs1_fwd, 32'd22);
        #1;
        reset = 1; wb_hold = 0;
        #1;
        chk("t6_count_rst", 32'(count), 0);
        chk("t6_we_rst", 32'(we), 0);
        chk("t6_hit_rst", 32'(rs1_hit), 0);
        chk("t6_fwd_rst", rs1_fwd, 0);
        chk("t6_mem_ready_rst", 32'(mem_ready), 1);
        tick();
        reset = 0;
        rs1 = 0;
        tick();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7;
        tick();
        alu_valid = 0;
        chk("t6_we_new", 32'(we), 1);
        chk("t6_rd_new", 32'(rd), 7);
        chk("t6_din_new", din, 32'h7);
        tick();
        chk("t6_count_end", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
